// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the fetch/data memory arbiter
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } requester_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and backing-memory handshake bundle for mem_arbiter
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_done;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_done;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  stall_f;
  logic                  stall_m;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
    output if_rdata, if_done, dm_rdata, dm_done, mem_req, mem_we, mem_addr, mem_wdata,
           stall_f, stall_m
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
    input  if_rdata, if_done, dm_rdata, dm_done, mem_req, mem_we, mem_addr, mem_wdata,
           stall_f, stall_m
  );

endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select; MEM_ARB_RR_EN enables round-robin tie-break
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_if_req,
  input  logic       i_dm_req,
  input  requester_t i_last_grant,
  input  logic [1:0] i_excl,
  output logic       o_valid,
  output requester_t o_winner
);

  logic w_if_cand;
  logic w_dm_cand;

  // i_excl masks out the requester just served at an ack edge
  assign w_if_cand = i_if_req & ~i_excl[0];
  assign w_dm_cand = i_dm_req & ~i_excl[1];
  assign o_valid   = w_if_cand | w_dm_cand;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    o_winner = REQ_IF;
    if (w_if_cand && w_dm_cand) begin
      if (i_last_grant == REQ_IF) o_winner = REQ_DM;
      else                        o_winner = REQ_IF;
    end else if (w_dm_cand) begin
      o_winner = REQ_DM;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last_grant;

  always_comb begin
    o_winner = REQ_IF;
    if (w_dm_cand) o_winner = REQ_DM;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one req/ack memory port (MEM_ARB_RR_EN: round-robin)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
)
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_GNT_IF = GNT_IF;
  localparam logic [1:0] S_GNT_DM = GNT_DM;

  logic [1:0]            r_state;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic       w_ack;
  logic       w_if_done;
  logic       w_dm_done;
  logic       w_arb;
  logic [1:0] w_excl;
  logic       w_pick_valid;
  requester_t w_winner;
  requester_t w_last_grant;

  // an ack only counts while a request is actually outstanding
  assign w_ack     = bus.mem_ack & r_mem_req;
  assign w_if_done = w_ack & (r_state == S_GNT_IF);
  assign w_dm_done = w_ack & (r_state == S_GNT_DM);
  assign w_arb     = (r_state == S_IDLE) | w_ack;
  assign w_excl    = {w_dm_done, w_if_done};

  mem_arb_pick u_pick (
    .i_if_req     (bus.if_req),
    .i_dm_req     (bus.dm_req),
    .i_last_grant (w_last_grant),
    .i_excl       (w_excl),
    .o_valid      (w_pick_valid),
    .o_winner     (w_winner)
  );

`ifdef MEM_ARB_RR_EN
  requester_t r_last_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= REQ_IF;
    end else if (w_arb && w_pick_valid) begin
      r_last_grant <= w_winner;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = REQ_IF;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_arb) begin
      if (w_pick_valid && (w_winner == REQ_DM)) begin
        r_state     <= S_GNT_DM;
        r_mem_req   <= 1'b1;
        r_mem_we    <= bus.dm_we;
        r_mem_addr  <= bus.dm_addr;
        r_mem_wdata <= bus.dm_wdata;
      end else if (w_pick_valid) begin
        r_state     <= S_GNT_IF;
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= bus.if_addr;
        r_mem_wdata <= '0;
      end else begin
        r_state   <= S_IDLE;
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

  assign bus.if_done  = w_if_done;
  assign bus.dm_done  = w_dm_done;
  assign bus.if_rdata = w_if_done ? bus.mem_rdata : '0;
  assign bus.dm_rdata = w_dm_done ? bus.mem_rdata : '0;

  // stalls drop in the done cycle so the pipeline advances on that edge
  assign bus.stall_f = bus.if_req & ~w_if_done;
  assign bus.stall_m = bus.dm_req & ~w_dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  // memory responder: ack after ack_wait idle cycles of each request
  int ack_wait = 0;
  bit resp_en  = 1'b1;
  int resp_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (resp_en) begin
      if (!rst || !bus.mem_req) begin
        bus.mem_ack = 1'b0;
        resp_cnt    = 0;
      end else begin
        if (bus.mem_ack) resp_cnt = 0;
        if (resp_cnt == ack_wait) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_val(bus.mem_addr);
        end else begin
          bus.mem_ack = 1'b0;
          resp_cnt++;
        end
      end
    end
  end

  // reference model: owner 0 = none, 1 = fetch, 2 = data
  int          m_owner = 0;
  int          m_last  = 1;
  logic        m_req   = 1'b0;
  logic        m_we    = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;

  always begin
    bit e_if, e_dm, served, c_if, c_dm;
    int pick;
    @(negedge clk);
    if (!rst) begin
      m_owner = 0; m_last = 1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    end
    e_if = rst && (m_owner == 1) && bus.mem_ack;
    e_dm = rst && (m_owner == 2) && bus.mem_ack;
    check("if_done", bus.if_done, e_if);
    check("dm_done", bus.dm_done, e_dm);
    check("if_rdata", bus.if_rdata, e_if ? bus.mem_rdata : 32'h0);
    if (!(e_dm && m_we)) check("dm_rdata", bus.dm_rdata, e_dm ? bus.mem_rdata : 32'h0);
    check("stall_f", bus.stall_f, bus.if_req && !e_if);
    check("stall_m", bus.stall_m, bus.dm_req && !e_dm);
    check("mem_req", bus.mem_req, m_req);
    check("mem_we", bus.mem_we, m_we);
    if (m_req || !rst) begin
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_wdata", bus.mem_wdata, m_wdata);
    end
    @(posedge clk);
    if (rst) begin
      served = (m_owner != 0) && bus.mem_ack;
      if (m_owner == 0 || served) begin
        c_if = bus.if_req && !(served && m_owner == 1);
        c_dm = bus.dm_req && !(served && m_owner == 2);
`ifdef MEM_ARB_RR_EN
        if (c_if && c_dm) pick = (m_last == 2) ? 1 : 2;
`else
        if (c_if && c_dm) pick = 2;
`endif
        else if (c_dm)    pick = 2;
        else if (c_if)    pick = 1;
        else              pick = 0;
        m_owner = pick;
        if (pick == 2) begin
          m_req = 1'b1; m_we = bus.dm_we; m_addr = bus.dm_addr; m_wdata = bus.dm_wdata; m_last = 2;
        end else if (pick == 1) begin
          m_req = 1'b1; m_we = 1'b0; m_addr = bus.if_addr; m_wdata = '0; m_last = 1;
        end else begin
          m_req = 1'b0; m_we = 1'b0;
        end
      end
    end
  end

  int          stall_f_cnt, if_pulses, dm_pulses, gap, run_cycles;
  logic [31:0] if_data;
  int          done_order[$];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // runs requesters until both have dropped; each drops on seeing its done
  task automatic run_until_idle(input int budget);
    bit drop_if, drop_dm, seen_first;
    stall_f_cnt = 0; if_pulses = 0; dm_pulses = 0; gap = 0; run_cycles = 0;
    if_data = '0; seen_first = 1'b0;
    done_order.delete();
    while ((bus.if_req || bus.dm_req) && run_cycles < budget) begin
      @(negedge clk);
      drop_if = bus.if_done;
      drop_dm = bus.dm_done;
      if (bus.stall_f) stall_f_cnt++;
      if (bus.if_done) begin if_pulses++; if_data = bus.if_rdata; done_order.push_back(1); end
      if (bus.dm_done) begin dm_pulses++; done_order.push_back(2); end
      if (seen_first && !bus.mem_req) gap++;
      if (drop_if || drop_dm) seen_first = 1'b1;
      @(posedge clk);
      #2;
      if (drop_if) bus.if_req = 1'b0;
      if (drop_dm) bus.dm_req = 1'b0;
      run_cycles++;
    end
    check("run_budget", bus.if_req || bus.dm_req, 1'b0);
  endtask

  initial begin
    int dm_cnt;
    logic [31:0] dm_data;
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_ack = 0; bus.mem_rdata = '0;

    // reset held with a data request pending
    bus.dm_req = 1'b1; bus.dm_addr = 32'h40; bus.dm_we = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_dm_done", bus.dm_done, 1'b0);
    check("rst_if_done", bus.if_done, 1'b0);
    check("rst_dm_rdata", bus.dm_rdata, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("rel_cycle0_mem_req", bus.mem_req, 1'b0);
    @(negedge clk);
    check("rel_mem_req", bus.mem_req, 1'b1);
    check("rel_mem_addr", bus.mem_addr, 32'h40);
    check("rel_dm_done", bus.dm_done, 1'b1);
    check("rel_dm_rdata", bus.dm_rdata, 32'hDEADBFAF);
    @(posedge clk); #2;
    bus.dm_req = 1'b0;
    tick();

    // fetch with three wait cycles
    ack_wait = 3; bus.if_addr = 32'h100; bus.if_req = 1'b1;
    run_until_idle(20);
    check("f3_stall_cycles", stall_f_cnt, 4);
    check("f3_done_pulses", if_pulses, 1);
    check("f3_rdata", if_data, 32'hDEADBEEF);
    check("f3_cycles", run_cycles, 5);
    tick();

    // simultaneous store and fetch: data first, fetch granted at the ack edge
    ack_wait = 1;
    bus.dm_we = 1'b1; bus.dm_addr = 32'h2000; bus.dm_wdata = 32'h55; bus.dm_req = 1'b1;
    bus.if_addr = 32'h300; bus.if_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("both_mem_req", bus.mem_req, 1'b1);
    check("both_mem_we", bus.mem_we, 1'b1);
    check("both_mem_addr", bus.mem_addr, 32'h2000);
    check("both_mem_wdata", bus.mem_wdata, 32'h55);
    run_until_idle(20);
    check("both_n_done", done_order.size(), 2);
    if (done_order.size() == 2) begin
      check("both_first", done_order[0], 2);
      check("both_second", done_order[1], 1);
    end
    check("both_gap", gap, 0);
    check("both_if_rdata", if_data, 32'hDEADBCEF);
    tick();

    // data-only load, then both at once from IDLE
    ack_wait = 0; bus.dm_we = 1'b0; bus.dm_addr = 32'h80; bus.dm_req = 1'b1;
    run_until_idle(10);
    check("dm_only_pulses", dm_pulses, 1);
    tick();
    bus.dm_addr = 32'h84; bus.dm_req = 1'b1; bus.if_addr = 32'h104; bus.if_req = 1'b1;
    run_until_idle(20);
    check("prio_n_done", done_order.size(), 2);
    if (done_order.size() == 2) begin
`ifdef MEM_ARB_RR_EN
      check("prio_first", done_order[0], 1);
`else
      check("prio_first", done_order[0], 2);
`endif
    end
    tick();

    // zero-wait fetch
    bus.if_addr = 32'h200; bus.if_req = 1'b1;
    run_until_idle(10);
    check("f0_cycles", run_cycles, 2);
    check("f0_stall_cycles", stall_f_cnt, 1);
    check("f0_rdata", if_data, 32'hDEADBDEF);
    tick();

    // spurious ack while idle
    resp_en = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234;
    @(negedge clk);
    check("spur_dm_done", bus.dm_done, 1'b0);
    check("spur_if_done", bus.if_done, 1'b0);
    check("spur_if_rdata", bus.if_rdata, 32'h0);
    tick();
    @(negedge clk);
    check("spur_mem_req", bus.mem_req, 1'b0);
    tick();
    bus.mem_ack = 1'b0; resp_en = 1'b1;
    tick();

    // asynchronous reset mid fetch grant
    ack_wait = 5; bus.if_addr = 32'h500; bus.if_req = 1'b1;
    tick(); tick();
    check("pre_rst_mem_req", bus.mem_req, 1'b1);
    rst = 1'b0;
    #1;
    check("async_rst_mem_req", bus.mem_req, 1'b0);
    check("async_rst_mem_addr", bus.mem_addr, 32'h0);
    bus.if_req = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();

    // data request dropped while granted still completes
    ack_wait = 2; bus.dm_we = 1'b0; bus.dm_addr = 32'h700; bus.dm_req = 1'b1;
    tick();
    bus.dm_req = 1'b0;
    dm_cnt = 0; dm_data = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.dm_done) begin dm_cnt++; dm_data = bus.dm_rdata; end
    end
    check("drop_dm_pulses", dm_cnt, 1);
    check("drop_dm_rdata", dm_data, 32'hDEADB8EF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
